// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, memory-wait freeze
// with timeout, halt handling and a saturating stall-cycle counter.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] IIDRs1,
  input  logic [15:0] IIDRs2,
  input  logic [15:0] IEXRd,
  input  logic        IEXMemRead,
  input  logic        IBranchTaken,
  input  logic        IMemReq,
  input  logic        IMemReady,
  input  logic        IHalt,
  output logic        OPCWrite,
  output logic        OIFIDWrite,
  output logic        OIDEXWrite,
  output logic        OEXMEMWrite,
  output logic        OMEMWBWrite,
  output logic        OIFIDFlush,
  output logic        OIDEXFlush,
  output logic        OHalted,
  output logic        OError,
  output logic [15:0] OStallCount
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  state_e      state_q, state_d, state_eff;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        error_q, error_d;
  logic        load_use, freeze, timeout;

  assign load_use = IEXMemRead && (IEXRd != 16'd0) && ((IEXRd == IIDRs1) || (IEXRd == IIDRs2));

  // While Reset is asserted the outputs already behave as in RUN.
  always_comb begin
    state_eff = state_q;
    if (Reset) state_eff = StRun;
  end

  always_comb begin
    freeze = 1'b0;
    unique case (state_eff)
      StRun:     freeze = IMemReq && !IMemReady;
      StMemWait: freeze = !IMemReady;
      default:   freeze = 1'b0;
    endcase
  end

  assign timeout = (state_q == StMemWait) && !IMemReady && (wait_cnt_q == 4'd15);

  always_comb begin
    OPCWrite    = 1'b1;
    OIFIDWrite  = 1'b1;
    OIDEXWrite  = 1'b1;
    OEXMEMWrite = 1'b1;
    OMEMWBWrite = 1'b1;
    OIFIDFlush  = 1'b0;
    OIDEXFlush  = 1'b0;
    if ((state_eff == StHalt) || freeze) begin
      OPCWrite    = 1'b0;
      OIFIDWrite  = 1'b0;
      OIDEXWrite  = 1'b0;
      OEXMEMWrite = 1'b0;
      OMEMWBWrite = 1'b0;
    end else if (IBranchTaken) begin
      OIFIDFlush = 1'b1;
      OIDEXFlush = 1'b1;
    end else if (load_use) begin
      OPCWrite   = 1'b0;
      OIFIDWrite = 1'b0;
      OIDEXFlush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q || timeout;
    unique case (state_q)
      StRun: begin
        if (IMemReq && !IMemReady) begin
          state_d    = StMemWait;
          wait_cnt_d = 4'd0;
        end
      end
      StMemWait: begin
        if (IMemReady) begin
          state_d = StRun;
        end else if (timeout) begin
          state_d = StHalt;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = StHalt;
    endcase
    if (IHalt && (state_q != StHalt)) state_d = StHalt;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StHalt) && !OPCWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      error_q     <= error_d;
    end
  end

  assign OHalted     = (state_eff == StHalt);
  assign OError      = error_q;
  assign OStallCount = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock, CLK; reset Reset is synchronous and active-high.
REQ-002 Ports SHALL be, as name direction width meaning:
- CLK in 1: clock, posedge.
- Reset in 1: synchronous active-high reset.
- IIDRs1 in 16: ID-stage source register 1 specifier.
- IIDRs2 in 16: ID-stage source register 2 specifier.
- IEXRd in 16: EX-stage destination specifier.
- IEXMemRead in 1: EX-stage instruction is a load.
- IBranchTaken in 1: EX-stage branch/jump resolved taken.
- IMemReq in 1: MEM-stage memory access active.
- IMemReady in 1: memory completes access this cycle.
- IHalt in 1: halt instruction reached WB.
- OPCWrite out 1: PC enable.
- OIFIDWrite out 1: IF_ID enable.
- OIDEXWrite out 1: ID_EX enable.
- OEXMEMWrite out 1: EX_MEM enable.
- OMEMWBWrite out 1: MEM_WB enable.
- OIFIDFlush out 1: IF_ID loads bubble.
- OIDEXFlush out 1: ID_EX loads bubble.
- OHalted out 1: core halted.
- OError out 1: memory timeout occurred (sticky).
- OStallCount out 16: stall-cycle performance counter.

Function
REQ-003 SHALL implement states RUN, MEM_WAIT, HALT; state and counters registered on posedge CLK, enable/flush outputs combinational from state and inputs.
REQ-004 Load-use hazard SHALL be IEXMemRead=1 and IEXRd!=0 and (IEXRd==IIDRs1 or IEXRd==IIDRs2), full 16-bit compare.
REQ-005 In RUN, with no memory wait, no branch, and no hazard: all five enables 1, both flushes 0.
REQ-006 In RUN, on load-use hazard with no branch: OPCWrite=0, OIFIDWrite=0, OIDEXFlush=1; other enables 1; single-cycle stall, no state change.
REQ-007 In RUN, on IBranchTaken=1: all enables 1, OIFIDFlush=1, OIDEXFlush=1; branch overrides load-use stall.
REQ-008 In RUN, if IMemReq=1 and IMemReady=0: all enables 0, flushes 0 in that same cycle; next state MEM_WAIT, wait counter cleared to 0.
REQ-009 In RUN, IMemReq=1 with IMemReady=1: no freeze, normal REQ-005..007 behaviour.
REQ-010 In MEM_WAIT, while IMemReady=0: all enables 0, flushes 0; 4-bit wait counter increments each cycle.
REQ-011 In MEM_WAIT, when IMemReady=1: behave as RUN for that cycle (REQ-005..007 apply); next state RUN.
REQ-012 If wait counter equals 15 and IMemReady=0 in MEM_WAIT: next state HALT, OError set to 1.
REQ-013 Memory freeze SHALL take priority over branch and load-use; branch/hazard inputs are held by frozen stages and are acted on when unfrozen.
REQ-014 IHalt=1 in RUN or MEM_WAIT: next state HALT; current-cycle outputs unaffected by IHalt.
REQ-015 In HALT: all enables 0, flushes 0, OHalted=1; state held until Reset; all other inputs ignored.
REQ-016 OStallCount SHALL increment by 1 each cycle OPCWrite=0 while state is not HALT, saturating at 0xFFFF.
REQ-017 OError, once set, SHALL remain 1 until Reset.

Reset
REQ-018 Reset=1 at posedge SHALL force state RUN, wait counter 0, OStallCount 0, OError 0, OHalted 0.
REQ-019 While Reset=1, outputs SHALL follow RUN-state combinational rules; Reset overrides all other events including HALT and mid-MEM_WAIT.

Verification
REQ-020 Load-use: IEXMemRead=1, IEXRd=3, IIDRs2=3 -> OPCWrite=0, OIFIDWrite=0, OIDEXFlush=1 for one cycle; OStallCount 0->1.
REQ-021 Branch+hazard same cycle: IBranchTaken=1 with REQ-020 inputs -> all enables 1, OIFIDFlush=1, OIDEXFlush=1; OStallCount unchanged.
REQ-022 Memory wait: IMemReq=1, IMemReady=0 for 3 cycles then 1 -> enables 0 for 3 cycles, 1 on ready cycle; state RUN after; OStallCount=3.
REQ-023 Timeout: IMemReq=1, IMemReady=0 held 17 cycles -> HALT entered, OError=1, OHalted=1, enables 0 thereafter.
REQ-024 Halt then reset: IHalt=1 -> OHalted=1 next cycle, held; Reset=1 one cycle -> OHalted=0, OStallCount=0, all enables 1.
REQ-025 IEXRd=0 with IEXMemRead=1, IIDRs1=0 -> no stall.
